// File: rtl/fp_result_checker.sv
// rtl/fp_result_checker.sv - checked, back-pressuring sink for FP divider results
// Buffers result beats, compares each in order against an expected ROM and keeps pass/fail stats.
module fp_result_checker #(
  parameter int NUM_VECTORS = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ULP_TOL     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_result_tdata,
  input  logic        s_axis_result_tvalid,
  output logic        s_axis_result_tready,
  input  logic        start,
  input  logic        chk_hold,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pass_count,
  output logic [7:0]  fail_count,
  output logic        first_fail_valid,
  output logic [7:0]  first_fail_idx,
  output logic [31:0] last_result,
  output logic [2:0]  last_class,
  output logic        mismatch
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  NV    = 8'(NUM_VECTORS);
  localparam logic [7:0]  NV_M1 = 8'(NUM_VECTORS - 1);
  localparam logic [30:0] TOL   = 31'(ULP_TOL);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state, next_state;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  acc_cnt, pop_idx, chk_cnt;
  logic        fifo_empty, fifo_full;
  logic        push, pop, enter_run;

  logic        chk_valid, chk_match;
  logic [31:0] chk_data;
  logic [7:0]  chk_idx;

  logic [31:0] head, expected;
  logic [30:0] mag_diff;
  logic        head_match;

  function automatic logic [2:0] classify(input logic [31:0] v);
    logic [2:0] c;
    if (v[30:23] == 8'hFF)
      c = (v[22:0] == 23'd0) ? 3'd3 : (v[22] ? 3'd4 : 3'd5);
    else if (v[30:23] == 8'h00)
      c = (v[22:0] == 23'd0) ? 3'd0 : 3'd1;
    else
      c = 3'd2;
    return c;
  endfunction

  function automatic logic [31:0] rom(input logic [2:0] i);
    logic [31:0] r;
    case (i)
      3'd0:    r = 32'h3f000000;
      3'd1:    r = 32'h40400000;
      3'd2:    r = 32'hbf800000;
      3'd3:    r = 32'h00000000;
      3'd4:    r = 32'h7f800000;
      3'd5:    r = 32'h7f800000;
      3'd6:    r = 32'h7fc00000;
      default: r = 32'h3f000000;
    endcase
    return r;
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign enter_run  = start && (state != S_RUN);

  assign s_axis_result_tready = (state == S_RUN) && !fifo_full && (acc_cnt < NV);
  assign push = s_axis_result_tvalid && s_axis_result_tready;
  assign pop  = !fifo_empty && !chk_hold && (state == S_RUN);

  assign head     = mem[rd_ptr[AW-1:0]];
  assign expected = rom(pop_idx[2:0]);

  // Magnitudes compared as unsigned 31-bit patterns: adjacent floats of one sign differ by 1.
  always_comb begin
    mag_diff   = (head[30:0] >= expected[30:0]) ? (head[30:0] - expected[30:0])
                                                : (expected[30:0] - head[30:0]);
    head_match = 1'b0;
    if ((expected[30:23] == 8'hFF) && (expected[22:0] != 23'd0))
      head_match = (head[30:23] == 8'hFF) && (head[22:0] != 23'd0);
    else if (expected[30:23] == 8'hFF)
      head_match = (head == expected);
    else if (expected[30:0] == 31'd0)
      head_match = (head[30:0] == 31'd0) && (head[31] == expected[31]);
    else
      head_match = (head[31] == expected[31]) && (head[30:23] != 8'hFF) && (mag_diff <= TOL);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= s_axis_result_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (chk_valid && (chk_cnt == NV_M1)) next_state = S_DONE;
      S_DONE:  if (start) next_state = S_RUN;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      acc_cnt          <= 8'd0;
      pop_idx          <= 8'd0;
      chk_cnt          <= 8'd0;
      chk_valid        <= 1'b0;
      chk_match        <= 1'b0;
      chk_data         <= 32'd0;
      chk_idx          <= 8'd0;
      pass_count       <= 8'd0;
      fail_count       <= 8'd0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 8'd0;
      last_result      <= 32'd0;
      last_class       <= 3'd0;
      mismatch         <= 1'b0;
    end else if (enter_run) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      acc_cnt          <= 8'd0;
      pop_idx          <= 8'd0;
      chk_cnt          <= 8'd0;
      chk_valid        <= 1'b0;
      pass_count       <= 8'd0;
      fail_count       <= 8'd0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= 8'd0;
      mismatch         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        acc_cnt <= acc_cnt + 8'd1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        pop_idx <= pop_idx + 8'd1;
      end
      // Compare result is registered at pop; statistics follow one edge later.
      chk_valid <= pop;
      chk_match <= head_match;
      chk_data  <= head;
      chk_idx   <= pop_idx;
      mismatch  <= chk_valid && !chk_match;
      if (chk_valid) begin
        chk_cnt     <= chk_cnt + 8'd1;
        last_result <= chk_data;
        last_class  <= classify(chk_data);
        if (chk_match) begin
          pass_count <= pass_count + 8'd1;
        end else begin
          fail_count <= fail_count + 8'd1;
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_idx   <= chk_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_result_checker.sv
// tb/tb_fp_result_checker.sv - scoreboard bench for fp_result_checker
// Two instances (ULP_TOL 0 and 1) share stimulus; expected results come from a reference model.
`timescale 1ns/1ps
module tb_fp_result_checker;

  logic        clk = 1'b0;
  logic        rst, start, chk_hold, tvalid;
  logic [31:0] tdata;

  logic        tready0, busy0, done0, ffv0, mm0;
  logic [7:0]  pc0, fc0, ffi0;
  logic [31:0] lr0;
  logic [2:0]  lc0;
  logic        tready1, busy1, done1, ffv1, mm1;
  logic [7:0]  pc1, fc1, ffi1;
  logic [31:0] lr1;
  logic [2:0]  lc1;

  always #5 clk = ~clk;

  fp_result_checker #(.NUM_VECTORS(8), .FIFO_DEPTH(4), .ULP_TOL(0)) dut0 (
    .clk(clk), .rst(rst), .s_axis_result_tdata(tdata), .s_axis_result_tvalid(tvalid),
    .s_axis_result_tready(tready0), .start(start), .chk_hold(chk_hold), .busy(busy0),
    .done(done0), .pass_count(pc0), .fail_count(fc0), .first_fail_valid(ffv0),
    .first_fail_idx(ffi0), .last_result(lr0), .last_class(lc0), .mismatch(mm0));

  fp_result_checker #(.NUM_VECTORS(8), .FIFO_DEPTH(4), .ULP_TOL(1)) dut1 (
    .clk(clk), .rst(rst), .s_axis_result_tdata(tdata), .s_axis_result_tvalid(tvalid),
    .s_axis_result_tready(tready1), .start(start), .chk_hold(chk_hold), .busy(busy1),
    .done(done1), .pass_count(pc1), .fail_count(fc1), .first_fail_valid(ffv1),
    .first_fail_idx(ffi1), .last_result(lr1), .last_class(lc1), .mismatch(mm1));

  typedef struct {
    logic [31:0] data;
    int          cls;
    bit          m [2];
  } exp_t;

  exp_t        exp_q[$];
  int          rd [2];
  int          prev_tot [2];
  int          prev_pc [2];
  int          n_vec = 0;
  int          n_mis = 0;

  int          acc_idx;
  int          ep [2];
  int          ef [2];
  bit          effv [2];
  int          effi [2];

  logic [31:0] rom_v [8] = '{32'h3f000000, 32'h40400000, 32'hbf800000, 32'h00000000,
                             32'h7f800000, 32'h7f800000, 32'h7fc00000, 32'h3f000000};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: IEEE-754 single fields treated as plain integers.
  function automatic int mcls(input logic [31:0] v);
    int e = int'(v[30:23]);
    int m = int'(v[22:0]);
    if (e == 255) return (m == 0) ? 3 : ((m >= (1 << 22)) ? 4 : 5);
    if (e == 0) return (m == 0) ? 0 : 1;
    return 2;
  endfunction

  function automatic bit mmatch(input logic [31:0] a, input logic [31:0] x, input int tol);
    int     ca = mcls(a);
    int     cx = mcls(x);
    longint d;
    if (cx >= 4) return ca >= 4;
    if (cx == 3) return a == x;
    if (cx == 0) return (ca == 0) && (a[31] == x[31]);
    if ((a[31] != x[31]) || (ca >= 3)) return 0;
    d = longint'(a[30:0]) - longint'(x[30:0]);
    if (d < 0) d = -d;
    return d <= longint'(tol);
  endfunction

  task automatic push_expected(input logic [31:0] v);
    exp_t e;
    e.data = v;
    e.cls  = mcls(v);
    for (int k = 0; k < 2; k++) begin
      e.m[k] = mmatch(v, rom_v[acc_idx % 8], k);
      if (e.m[k]) ep[k]++;
      else begin
        ef[k]++;
        if (!effv[k]) begin
          effv[k] = 1;
          effi[k] = acc_idx;
        end
      end
    end
    exp_q.push_back(e);
    acc_idx++;
  endtask

  task automatic mon(input int k, input logic [7:0] pc, input logic [7:0] fc,
                     input logic [31:0] lr, input logic [2:0] lc, input logic mm);
    int   tot = int'(pc) + int'(fc);
    exp_t e;
    if (tot == prev_tot[k] + 1) begin
      if (rd[k] >= exp_q.size()) begin
        chk($sformatf("unexpected_check%0d", k), 32'(tot), 32'(prev_tot[k]));
      end else begin
        e = exp_q[rd[k]];
        rd[k]++;
        chk($sformatf("last_result%0d", k), lr, e.data);
        chk($sformatf("last_class%0d", k), 32'(lc), 32'(e.cls));
        chk($sformatf("pass_step%0d", k), 32'(int'(pc) - prev_pc[k]), 32'(e.m[k]));
        chk($sformatf("mismatch_pulse%0d", k), 32'(mm), 32'(!e.m[k]));
      end
    end else if ((tot != prev_tot[k]) && (tot != 0)) begin
      chk($sformatf("count_jump%0d", k), 32'(tot), 32'(prev_tot[k] + 1));
    end else if (mm) begin
      chk($sformatf("mismatch_idle%0d", k), 32'(mm), 32'd0);
    end
    prev_tot[k] = tot;
    prev_pc[k]  = int'(pc);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_tot = '{0, 0};
      prev_pc  = '{0, 0};
    end else begin
      mon(0, pc0, fc0, lr0, lc0, mm0);
      mon(1, pc1, fc1, lr1, lc1, mm1);
    end
  end

  // Called at a falling edge; returns at a falling edge.
  task automatic offer(input logic [31:0] v, input bit rhold, input int max_wait, output bit acc);
    acc    = 0;
    tdata  = v;
    tvalid = 1'b1;
    for (int c = 0; c < max_wait && !acc; c++) begin
      if (rhold) chk_hold = ($urandom_range(3) == 0);
      #1;
      if (tready0) begin
        acc = 1;
        push_expected(v);
      end
      @(negedge clk);
    end
    tvalid = 1'b0;
  endtask

  task automatic pulse_start();
    acc_idx = 0;
    ep = '{0, 0};
    ef = '{0, 0};
    effv = '{0, 0};
    effi = '{0, 0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run();
    for (int c = 0; c < 100 && !(done0 && done1); c++) @(negedge clk);
    #1;
    chk("done0", 32'(done0), 32'd1);
    chk("done1", 32'(done1), 32'd1);
    chk("busy0_end", 32'(busy0), 32'd0);
    chk("tready0_end", 32'(tready0), 32'd0);
    chk("pass0", 32'(pc0), 32'(ep[0]));
    chk("fail0", 32'(fc0), 32'(ef[0]));
    chk("pass1", 32'(pc1), 32'(ep[1]));
    chk("fail1", 32'(fc1), 32'(ef[1]));
    chk("ffv0", 32'(ffv0), 32'(effv[0]));
    chk("ffv1", 32'(ffv1), 32'(effv[1]));
    if (effv[0]) chk("ffi0", 32'(ffi0), 32'(effi[0]));
    if (effv[1]) chk("ffi1", 32'(ffi1), 32'(effi[1]));
    chk("drained0", 32'(rd[0]), 32'(exp_q.size()));
    chk("drained1", 32'(rd[1]), 32'(exp_q.size()));
    @(negedge clk);
  endtask

  task automatic do_run(input logic [31:0] v [8], input bit rhold, input bit ninth);
    bit acc;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      if (rhold) repeat ($urandom_range(2)) @(negedge clk);
      offer(v[i], rhold, 200, acc);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    end
    if (ninth) begin
      offer(32'h3f000000, 1'b0, 20, acc);
      chk("ninth_accepted", 32'(acc), 32'd0);
    end
    chk_hold = 1'b0;
    finish_run();
  endtask

  function automatic logic [31:0] gen(input int i);
    logic [31:0] x = rom_v[i];
    case ($urandom_range(7))
      0, 1, 2: return x;
      3:       return x + 32'd1;
      4:       return x - 32'd1;
      5:       return x ^ 32'h80000000;
      6:       return {1'($urandom_range(1)), 8'hFF, 23'($urandom_range(32'h7FFFFF, 1))};
      default: return $urandom;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_tready"}, 32'(tready0), 32'd0);
    chk({tag, "_busy"}, 32'(busy0), 32'd0);
    chk({tag, "_done"}, 32'(done0), 32'd0);
    chk({tag, "_pass"}, 32'(pc0), 32'd0);
    chk({tag, "_fail"}, 32'(fc0), 32'd0);
    chk({tag, "_ffv"}, 32'(ffv0), 32'd0);
    chk({tag, "_ffi"}, 32'(ffi0), 32'd0);
    chk({tag, "_last"}, lr0, 32'd0);
    chk({tag, "_class"}, 32'(lc0), 32'd0);
    chk({tag, "_mm"}, 32'(mm0), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v [8];
    bit acc;
    rst = 1'b1; start = 1'b0; chk_hold = 1'b0; tvalid = 1'b0; tdata = 32'd0;
    rd = '{0, 0};
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", 32'(tready0), 32'd0);

    do_run(rom_v, 1'b0, 1'b0);
    v = rom_v; v[2] = 32'h3f800000; do_run(v, 1'b0, 1'b0);
    v = rom_v; v[6] = 32'hffc00001; do_run(v, 1'b0, 1'b0);
    v = rom_v; v[6] = 32'h7f800001; do_run(v, 1'b0, 1'b0);
    v = rom_v; v[1] = 32'h40400001; do_run(v, 1'b0, 1'b0);
    v = rom_v; v[1] = 32'hc0400000; do_run(v, 1'b0, 1'b0);

    // Held check stage: FIFO fills, then releases.
    pulse_start();
    chk_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(rom_v[i], 1'b0, 20, acc);
      chk("hold_accept", 32'(acc), 32'd1);
    end
    offer(rom_v[4], 1'b0, 10, acc);
    chk("hold_full_no_accept", 32'(acc), 32'd0);
    chk("hold_tready", 32'(tready0), 32'd0);
    chk("hold_no_checks", 32'(pc0), 32'd0);
    chk_hold = 1'b0;
    @(negedge clk);
    chk("tready_return", 32'(tready0), 32'd1);
    for (int i = 4; i < 8; i++) begin
      offer(rom_v[i], 1'b0, 20, acc);
      chk("post_hold_accept", 32'(acc), 32'd1);
    end
    finish_run();

    // Reset in the middle of a run.
    pulse_start();
    for (int i = 0; i < 3; i++) offer(rom_v[i], 1'b0, 20, acc);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    exp_q.delete();
    rd = '{0, 0};
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_rst");
    do_run(rom_v, 1'b0, 1'b1);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 8; i++) v[i] = gen(i);
      do_run(v, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
